// File: rtl/cmd_decoder.sv
// Text-mode command decoder: pulls bytes from the shared register, parses 1-3 byte commands
// and issues single-cycle {attr,char} writes into the character RAM.
`timescale 1ns/1ps
module cmd_decoder #(
  parameter int unsigned COLS   = 100,
  parameter int unsigned ROWS   = 75,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              has_data,
  input  logic [7:0]        rd_data,
  output logic              rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              bad_cmd
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CUR   = 8'h01;
  localparam logic [7:0] OP_ATTR  = 8'h02;
  localparam logic [7:0] OP_PUT   = 8'h03;
  localparam logic [7:0] OP_CLEAR = 8'h04;

  typedef enum logic [2:0] {S_OP, S_ARG1, S_ARG2, S_EXEC, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic              rel_wait_q;
  logic [7:0]        op_q, arg1_q, arg2_q, attr_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] row_base_q, clr_addr_q;

  logic              accept, op_bad, cur_valid;
  logic              rd_d, we_d, bad_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;

  assign accept    = has_data && !rel_wait_q && (state_q inside {S_OP, S_ARG1, S_ARG2});
  assign op_bad    = op_q > OP_CLEAR;
  assign cur_valid = (32'(arg1_q) < COLS) && (32'(arg2_q) < ROWS);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_OP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OP: if (accept) begin
        // unknown opcodes also pass through EXEC so bad_cmd lands one cycle after the read
        if (rd_data == OP_CUR || rd_data == OP_ATTR || rd_data == OP_PUT) state_d = S_ARG1;
        else                                                              state_d = S_EXEC;
      end
      S_ARG1:  if (accept) state_d = (op_q == OP_CUR) ? S_ARG2 : S_EXEC;
      S_ARG2:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_CLEAR) ? S_CLEAR : S_OP;
      S_CLEAR: if (clr_addr_q == ADDR_LAST) state_d = S_OP;
      default: state_d = S_OP;
    endcase
  end

  always_comb begin
    rd_d    = accept;
    we_d    = 1'b0;
    bad_d   = 1'b0;
    busy_d  = state_q != S_OP;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state_q)
      S_EXEC: begin
        if (op_q == OP_PUT) begin
          we_d    = 1'b1;
          addr_d  = row_base_q + ADDR_W'(col_q);
          wdata_d = {attr_q, arg1_q};
        end else if (op_bad) begin
          bad_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_CLEAR: begin
        we_d    = 1'b1;
        addr_d  = clr_addr_q;
        wdata_d = {attr_q, 8'h20};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd        <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      rd        <= rd_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      bad_cmd   <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rel_wait_q <= 1'b0;
      op_q       <= OP_NOP;
      arg1_q     <= '0;
      arg2_q     <= '0;
      attr_q     <= 8'h0F;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      clr_addr_q <= '0;
    end else begin
      if (accept)         rel_wait_q <= 1'b1;
      else if (!has_data) rel_wait_q <= 1'b0;

      if (accept) begin
        case (state_q)
          S_OP:    op_q   <= rd_data;
          S_ARG1:  arg1_q <= rd_data;
          S_ARG2:  arg2_q <= rd_data;
          default: ;
        endcase
      end

      if (state_q == S_EXEC) begin
        case (op_q)
          OP_CUR: if (cur_valid) begin
            col_q      <= CW'(arg1_q);
            row_q      <= RW'(arg2_q);
            // product with a constant: reduces to shifts and adds
            row_base_q <= ADDR_W'(arg2_q) * COLS_A;
          end
          OP_ATTR: attr_q <= arg1_q;
          OP_PUT: begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q      <= '0;
                row_base_q <= '0;
              end else begin
                row_q      <= row_q + 1'b1;
                row_base_q <= row_base_q + COLS_A;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
          OP_CLEAR: clr_addr_q <= '0;
          default: ;
        endcase
      end

      if (state_q == S_CLEAR) begin
        clr_addr_q <= clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_LAST) begin
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: drives the shared-register handshake and checks RAM writes.
`timescale 1ns/1ps
module tb_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst, has_data, rd, mem_we, busy, bad_cmd;
  logic [7:0]  rd_data;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;

  typedef struct packed {logic [12:0] a; logic [15:0] d;} wr_t;
  wr_t wq[$];
  int  rd_cnt = 0, bad_cnt = 0;
  int unsigned total = 0, passed = 0;

  cmd_decoder #(.COLS(100), .ROWS(75), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst), .has_data(has_data), .rd_data(rd_data), .rd(rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we)  wq.push_back({mem_addr, mem_wdata});
    if (rd)      rd_cnt++;
    if (bad_cmd) bad_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // present one byte, wait for rd, then drop has_data for one edge
  task automatic send(input logic [7:0] b);
    int n;
    has_data = 1'b1;
    rd_data  = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd && n < 50);
    if (!rd) chk("rd_timeout", 32'd0, 32'd1);
    has_data = 1'b0;
    tick();
  endtask

  task automatic put_expect(input string tag, input logic [7:0] ch,
                            input logic [12:0] a, input logic [15:0] d);
    wq.delete();
    send(8'h03);
    send(ch);
    repeat (3) tick();
    chk({tag, "_count"}, wq.size(), 1);
    if (wq.size() > 0) begin
      chk({tag, "_addr"}, 32'(wq[0].a), 32'(a));
      chk({tag, "_data"}, 32'(wq[0].d), 32'(d));
    end
  endtask

  initial begin
    int n, act, busy_low, rdc0, bad0;
    logic seq_ok;

    rst = 1'b1; has_data = 1'b0; rd_data = 8'h00;
    repeat (3) tick();
    chk("rst_rd", 32'(rd), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bad", 32'(bad_cmd), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd || mem_we || busy || bad_cmd) act++;
    end
    chk("idle_activity", 32'(act), 0);

    put_expect("put0", 8'h41, 13'd0, 16'h0F41);
    put_expect("put1", 8'h42, 13'd1, 16'h0F42);

    send(8'h01); send(8'h63); send(8'h4A);
    send(8'h02); send(8'h1E);
    put_expect("corner", 8'h58, 13'd7499, 16'h1E58);
    put_expect("wrap", 8'h59, 13'd0, 16'h1E59);

    bad0 = bad_cnt;
    send(8'h01); send(8'h64); send(8'h00);
    put_expect("badcur", 8'h41, 13'd1, 16'h1E41);
    chk("badcur_nopulse", 32'(bad_cnt - bad0), 0);

    send(8'h02); send(8'h07);
    wq.delete();
    rdc0 = rd_cnt;
    send(8'h04);
    has_data = 1'b1;
    rd_data  = 8'h03;
    busy_low = 0;
    n = 0;
    while (wq.size() < 7500 && n < 8000) begin
      if (!busy) busy_low++;
      tick();
      n++;
    end
    has_data = 1'b0;
    chk("clr_count", wq.size(), 7500);
    chk("clr_busy_low", 32'(busy_low), 0);
    chk("clr_rd", 32'(rd_cnt - rdc0), 1);
    seq_ok = 1'b1;
    foreach (wq[i]) if (wq[i].a !== 13'(i) || wq[i].d !== 16'h0720) seq_ok = 1'b0;
    chk("clr_seq", 32'(seq_ok), 1);
    repeat (3) tick();
    chk("clr_busy_end", 32'(busy), 0);
    put_expect("after_clr", 8'h41, 13'd0, 16'h0741);

    bad0 = bad_cnt;
    wq.delete();
    send(8'h9C);
    repeat (4) tick();
    chk("bad_pulse", 32'(bad_cnt - bad0), 1);
    chk("bad_nowrite", wq.size(), 0);

    rdc0 = rd_cnt;
    has_data = 1'b1;
    rd_data  = 8'h03;
    n = 0;
    while (!rd && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    has_data = 1'b0;
    repeat (2) tick();
    chk("hold_one_rd", 32'(rd_cnt - rdc0), 1);
    wq.delete();
    send(8'h5A);
    repeat (3) tick();
    chk("hold_count", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("hold_addr", 32'(wq[0].a), 1);
      chk("hold_data", 32'(wq[0].d), 32'h075A);
    end

    wq.delete();
    send(8'h04);
    n = 0;
    while (wq.size() < 1001 && n < 1200) begin
      tick();
      n++;
    end
    chk("rstclr_reach", wq.size(), 1001);
    if (wq.size() > 1000) chk("rstclr_addr", 32'(wq[1000].a), 1000);
    rst = 1'b1;
    tick();
    chk("rstclr_we", 32'(mem_we), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rstclr_nowrites", wq.size(), 1001);
    chk("rstclr_busy", 32'(busy), 0);
    put_expect("post_rst", 8'h41, 13'd0, 16'h0F41);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
